pwm_preconditioner: RTL and testbench
=====================================

Name: pwm_preconditioner

Overview:
- Sits directly downstream of the per-transducer duty/phase filter and upstream of the PWM generators.
- Consumes the filter's serial stream of filtered DUTY/PHASE, one entry per transducer in index order 0..DEPTH-1.
- Converts each entry into PWM RISE/FALL edge times within that transducer's cycle, stores them in a shadow buffer, and commits all DEPTH entries atomically to its outputs.

Parameters:
- WIDTH, 13, bit width of duty/phase/cycle/edge values.
- DEPTH, 249, number of transducers per set.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- DIN_VALID  in  1  DUTY/PHASE hold a valid entry this cycle.
- DUTY  in  WIDTH  filtered duty, 0..CYCLE[i].
- PHASE  in  WIDTH  filtered phase, 0..CYCLE[i]-1.
- CYCLE  in  WIDTH x DEPTH  per-transducer period T[i].
- RISE  out  WIDTH x DEPTH  committed rise time per transducer.
- FALL  out  WIDTH x DEPTH  committed fall time per transducer.
- DOUT_VALID  out  1  one-cycle pulse when a new set is committed.

Behaviour:
- Reset (async, RST_N=0): RISE[*]=0, FALL[*]=0, DOUT_VALID=0, write index=0, pipeline valids=0, shadow contents discarded.
- Write index idx: increments on each sampled DIN_VALID; after DEPTH-1 it wraps to 0. Gaps between valids are allowed. There is no frame marker; entry i is the i-th valid since reset or the last wrap.
- Pipeline, valid bit travels with data:
  - S0 (edge k): register DUTY, PHASE, CYCLE[idx], idx.
  - S1 (edge k+1): lo=DUTY>>1, hi=(DUTY+1)>>1. r=PHASE-lo and f=PHASE+hi as signed WIDTH+2 values.
  - S2 (edge k+2): if r<0 then r+=T. If f>=T then f-=T. Special cases:
    - DUTY==0: RISE=0, FALL=0 (always off).
    - DUTY>=T: RISE=0, FALL=T (always on; the PWM treats FALL==T as never falling).
  - S3 (edge k+3): write r/f into shadow[idx].
- Commit: the cycle after the shadow write of index DEPTH-1 (edge k+4 for the last entry), all RISE/FALL outputs load from shadow in one edge and DOUT_VALID=1 for exactly one cycle. RISE/FALL never change at any other time.
- Latency: last DIN_VALID sampled at edge n gives outputs updated and DOUT_VALID high after edge n+4.
- Back-to-back sets: the next set's entry 0 may be written to shadow on the commit edge. The commit samples pre-edge shadow contents, so no corruption occurs. No stall and no backpressure.
- Result widths: results are always in [0,T-1], except FALL=T in the always-on case. Intermediates use WIDTH+2 bits signed, so there is no overflow for T<=2^WIDTH-1.
- T==0 entry: RISE=0, FALL=0.
- Reset mid-set: the partial set is dropped, outputs clear to 0, and the next valid is index 0.

Decomposition:
- Shared package: WIDTH/DEPTH defaults and a packed struct {valid, idx, duty, phase, cycle} for the pipeline stages.
- One sub-module, pwm_edge_calc: the S1–S2 per-entry arithmetic, pipelined at 2 cycles, with the special-case rules.
- The top level holds the index counter, S0/S3 registers, shadow RAM and commit logic.

Test Plan (WIDTH=13, all T=4096 unless stated):
- Mid-range entry: DUTY=2048, PHASE=1024 at index 0 -> RISE[0]=0, FALL[0]=2048.
- Rise wrap: DUTY=1000, PHASE=100 -> RISE=3696, FALL=600.
- Fall wrap with odd duty: DUTY=301, PHASE=4000 -> RISE=3850, FALL=55.
- Special cases: DUTY=0, PHASE=777 -> RISE=0, FALL=0. DUTY=4096, PHASE=5 -> RISE=0, FALL=4096.
- Commit timing: stream 249 valids with random gaps, last at edge n.
  - RISE/FALL stay at the previous values through edge n+3.
  - They update at n+4, with DOUT_VALID high for one cycle only.
  - A second set started at n+1 commits correctly, with index 0 unaffected.
- Reset mid-set: assert RST_N=0 after 100 entries -> outputs 0 and DOUT_VALID=0. A following full set of 249 entries commits with correct index alignment (entry 0 lands in RISE[0]).

Source files
------------

// File: rtl/pwm_preconditioner_pkg.sv
// Shared sizing, pipeline entry/edge structs and a signed-widening helper for the PWM preconditioner.
// Pure definitions: no latency, no flow control.
package pwm_preconditioner_pkg;
  localparam int WIDTH = 13;
  localparam int DEPTH = 249;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SW    = WIDTH + 2;

  typedef logic [WIDTH-1:0]            val_t;
  typedef logic [IDX_W-1:0]            idx_t;
  typedef logic signed [SW-1:0]        sval_t;
  typedef logic [DEPTH-1:0][WIDTH-1:0] vec_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
    val_t duty;
    val_t phase;
    val_t cycle;
  } entry_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
    val_t rise;
    val_t fall;
  } edge_t;

  localparam idx_t LAST_IDX = idx_t'(DEPTH - 1);

  function automatic sval_t widen(val_t v);
    return sval_t'({2'b00, v});
  endfunction
endpackage

// File: rtl/pwm_preconditioner_if.sv
// Duty/phase input stream and committed RISE/FALL vectors between the filter, preconditioner and PWM bank.
// Stream has no ready: the producer pushes one entry per din_vld, the consumer always accepts.
interface pwm_preconditioner_if;
  import pwm_preconditioner_pkg::*;

  logic din_vld;
  val_t duty;
  val_t phase;
  vec_t cycle;
  vec_t rise;
  vec_t fall;
  logic dout_vld;

  modport master (output din_vld, duty, phase, cycle, input rise, fall, dout_vld);
  modport slave  (input din_vld, duty, phase, cycle, output rise, fall, dout_vld);
endinterface

// File: rtl/pwm_edge_calc.sv
// Per-entry duty/phase to rise/fall edge arithmetic with off/on special cases.
// Latency 2 cycles; fully pipelined, no backpressure.
module pwm_edge_calc
  import pwm_preconditioner_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  entry_t ent_i,
  output edge_t  edge_o
);
  logic  valid_q;
  idx_t  idx_q;
  val_t  cycle_q;
  logic  off_q, on_q;
  sval_t r_q, f_q, r_d, f_d;
  val_t  lo;
  logic [WIDTH:0] hi;
  sval_t r_w, f_w;
  edge_t edge_d, edge_q;

  // Odd duty puts the extra count after the phase centre.
  always_comb begin
    lo  = ent_i.duty >> 1;
    hi  = ({1'b0, ent_i.duty} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    r_d = widen(ent_i.phase) - widen(lo);
    f_d = widen(ent_i.phase) + sval_t'({1'b0, hi});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      cycle_q <= '0;
      off_q   <= 1'b0;
      on_q    <= 1'b0;
      r_q     <= '0;
      f_q     <= '0;
    end else begin
      valid_q <= ent_i.valid;
      idx_q   <= ent_i.idx;
      cycle_q <= ent_i.cycle;
      off_q   <= (ent_i.duty == '0) || (ent_i.cycle == '0);
      on_q    <= ent_i.duty >= ent_i.cycle;
      r_q     <= r_d;
      f_q     <= f_d;
    end
  end

  always_comb begin
    r_w = r_q;
    f_w = f_q;
    if (r_q[SW-1]) r_w = r_q + widen(cycle_q);
    if (f_q >= widen(cycle_q)) f_w = f_q - widen(cycle_q);
    edge_d       = '0;
    edge_d.valid = valid_q;
    edge_d.idx   = idx_q;
    edge_d.rise  = r_w[WIDTH-1:0];
    edge_d.fall  = f_w[WIDTH-1:0];
    // FALL==T tells the PWM never to fall.
    if (off_q) begin
      edge_d.rise = '0;
      edge_d.fall = '0;
    end else if (on_q) begin
      edge_d.rise = '0;
      edge_d.fall = cycle_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) edge_q <= '0;
    else         edge_q <= edge_d;
  end

  assign edge_o = edge_q;
endmodule

// File: rtl/pwm_preconditioner.sv
// Indexes the duty/phase stream, computes edges into a shadow buffer and commits all entries at once.
// Last entry to outputs/dout_vld is 4 cycles; never stalls, no backpressure.
module pwm_preconditioner
  import pwm_preconditioner_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  pwm_preconditioner_if.slave bus
);
  idx_t   idx_q;
  entry_t s0_q;
  edge_t  s2;
  logic   commit_q, dout_vld_q;
  vec_t   shadow_rise_q, shadow_fall_q;
  vec_t   rise_q, fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      s0_q  <= '0;
    end else begin
      s0_q.valid <= bus.din_vld;
      if (bus.din_vld) begin
        s0_q.idx   <= idx_q;
        s0_q.duty  <= bus.duty;
        s0_q.phase <= bus.phase;
        s0_q.cycle <= bus.cycle[idx_q];
        idx_q      <= (idx_q == LAST_IDX) ? '0 : idx_q + idx_t'(1);
      end
    end
  end

  pwm_edge_calc u_edge_calc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ent_i  (s0_q),
    .edge_o (s2)
  );

  // Shadow contents are don't-care until a full set has been written.
  always_ff @(posedge clk_i) begin
    if (s2.valid) begin
      shadow_rise_q[s2.idx] <= s2.rise;
      shadow_fall_q[s2.idx] <= s2.fall;
    end
  end

  // Commit reads pre-edge shadow, so the next set's entry 0 may land on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      commit_q   <= 1'b0;
      dout_vld_q <= 1'b0;
      rise_q     <= '0;
      fall_q     <= '0;
    end else begin
      commit_q   <= s2.valid && (s2.idx == LAST_IDX);
      dout_vld_q <= commit_q;
      if (commit_q) begin
        rise_q <= shadow_rise_q;
        fall_q <= shadow_fall_q;
      end
    end
  end

  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.dout_vld = dout_vld_q;
endmodule

// File: tb/tb_pwm_preconditioner.sv
// Directed + random sets through pwm_preconditioner, scoreboarded against a reference edge model.
module tb_pwm_preconditioner;
  import pwm_preconditioner_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_preconditioner_if bus();
  pwm_preconditioner dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct packed { val_t r; val_t f; } ent_t;
  ent_t sb[$];
  int   commit_cyc[$];
  vec_t exp_rise, exp_fall, cyc_cfg;
  vec_t snap_rise[4], snap_fall[4];
  int   errors = 0, checks = 0, cyc = 0, tb_idx = 0;
  int   n_a, n_b, n_c, n_d;
  logic prev_dv = 1'b0;

  function automatic ent_t model(int duty, int phase, int t);
    int r, f;
    ent_t e;
    if (t == 0 || duty == 0) begin r = 0; f = 0; end
    else if (duty >= t) begin r = 0; f = t; end
    else begin
      r = phase - duty / 2;
      if (r < 0) r += t;
      f = phase + (duty + 1) / 2;
      if (f >= t) f -= t;
    end
    e.r = val_t'(r);
    e.f = val_t'(f);
    return e;
  endfunction

  function automatic int commit_at(int k);
    return (k < commit_cyc.size()) ? commit_cyc[k] : -1;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_arr(string tag, vec_t got, vec_t exp);
    int bad;
    checks++;
    assert (got === exp) else begin
      errors++;
      bad = 0;
      for (int i = DEPTH - 1; i >= 0; i--) if (got[i] !== exp[i]) bad = i;
      $error("FAIL %s entry %0d: got %0d expected %0d", tag, bad, got[bad], exp[bad]);
    end
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.dout_vld === 1'b1) begin
      commit_cyc.push_back(cyc);
      chk("dout_one_cycle", prev_dv, 0);
      chk("commit_has_full_set", sb.size() >= DEPTH, 1);
      if (sb.size() >= DEPTH) begin
        for (int i = 0; i < DEPTH; i++) begin
          e = sb.pop_front();
          exp_rise[i] = e.r;
          exp_fall[i] = e.f;
        end
      end
      if (commit_cyc.size() <= 4) begin
        snap_rise[commit_cyc.size()-1] = bus.rise;
        snap_fall[commit_cyc.size()-1] = bus.fall;
      end
    end
    prev_dv = bus.dout_vld;
    chk_arr("rise", bus.rise, exp_rise);
    chk_arr("fall", bus.fall, exp_fall);
  endtask

  task automatic send(int duty, int phase, int gap);
    bus.din_vld = 1'b1;
    bus.duty    = val_t'(duty);
    bus.phase   = val_t'(phase);
    sb.push_back(model(duty, phase, int'(cyc_cfg[tb_idx])));
    tb_idx = (tb_idx + 1) % DEPTH;
    tick();
    bus.din_vld = 1'b0;
    bus.duty    = val_t'($urandom);
    bus.phase   = val_t'($urandom);
    repeat (gap) tick();
  endtask

  task automatic rand_send(int gapmax);
    int t;
    t = int'(cyc_cfg[tb_idx]);
    if (t == 0) send(0, 0, $urandom_range(0, gapmax));
    else send($urandom_range(0, t), $urandom_range(0, t - 1), $urandom_range(0, gapmax));
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.din_vld = 1'b0;
    bus.duty    = '0;
    bus.phase   = '0;
    for (int i = 0; i < DEPTH; i++) cyc_cfg[i] = val_t'(4096);
    bus.cycle = cyc_cfg;
    exp_rise  = '0;
    exp_fall  = '0;
    repeat (3) tick();
    chk("reset_dout_vld", bus.dout_vld, 0);
    rst_n = 1'b1;
    tick();

    // Set A: directed entries 0..4, last entry followed immediately by set B
    send(2048, 1024, 1);
    send(1000, 100, 0);
    send(301, 4000, 2);
    send(0, 777, 1);
    send(4096, 5, 0);
    for (int i = 5; i < DEPTH - 1; i++) rand_send(2);
    rand_send(0);
    n_a = cyc;
    send(100, 50, 1);
    for (int i = 1; i < DEPTH - 1; i++) rand_send(1);
    rand_send(0);
    n_b = cyc;
    repeat (8) tick();
    chk("commits_after_AB", commit_cyc.size(), 2);
    chk("commit_A_cycle", commit_at(0), n_a + 4);
    chk("commit_B_cycle", commit_at(1), n_b + 4);
    chk("A_rise0", snap_rise[0][0], 0);
    chk("A_fall0", snap_fall[0][0], 2048);
    chk("A_rise1", snap_rise[0][1], 3696);
    chk("A_fall1", snap_fall[0][1], 600);
    chk("A_rise2", snap_rise[0][2], 3850);
    chk("A_fall2", snap_fall[0][2], 55);
    chk("A_rise3_off", snap_rise[0][3], 0);
    chk("A_fall3_off", snap_fall[0][3], 0);
    chk("A_rise4_on", snap_rise[0][4], 0);
    chk("A_fall4_on", snap_fall[0][4], 4096);
    chk("B_rise0", snap_rise[1][0], 0);
    chk("B_fall0", snap_fall[1][0], 100);

    // Set C: per-transducer periods, including T=0 and the maximum period
    for (int i = 0; i < DEPTH; i++) cyc_cfg[i] = val_t'($urandom_range(1, 8191));
    cyc_cfg[7] = '0;
    cyc_cfg[8] = val_t'(8191);
    bus.cycle  = cyc_cfg;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 7)      send(5, 3, 1);
      else if (i == 8) send(8190, 8190, 1);
      else             rand_send(3);
    end
    n_c = cyc;
    repeat (8) tick();
    chk("commits_after_C", commit_cyc.size(), 3);
    chk("commit_C_cycle", commit_at(2), n_c + 4);
    chk("C_rise7_t0", snap_rise[2][7], 0);
    chk("C_fall7_t0", snap_fall[2][7], 0);
    chk("C_rise8_tmax", snap_rise[2][8], 4095);
    chk("C_fall8_tmax", snap_fall[2][8], 4094);

    // Reset after 100 entries of a partial set
    for (int i = 0; i < DEPTH; i++) cyc_cfg[i] = val_t'(4096);
    bus.cycle = cyc_cfg;
    for (int i = 0; i < 100; i++) rand_send(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout_vld", bus.dout_vld, 0);
    chk("midrst_rise_zero", bus.rise === '0, 1);
    chk("midrst_fall_zero", bus.fall === '0, 1);
    sb.delete();
    tb_idx   = 0;
    exp_rise = '0;
    exp_fall = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(2048, 1024, 1);
    for (int i = 1; i < DEPTH - 1; i++) rand_send(2);
    rand_send(0);
    n_d = cyc;
    repeat (8) tick();
    chk("commits_after_D", commit_cyc.size(), 4);
    chk("commit_D_cycle", commit_at(3), n_d + 4);
    chk("D_rise0", snap_rise[3][0], 0);
    chk("D_fall0", snap_fall[3][0], 2048);
    chk("sb_empty_at_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
